soc_system_sysid_checker: RTL and testbench
===========================================

// Module: soc_system_sysid_checker
// PURPOSE
//  Avalon-MM read master for the system-ID slave. On start it reads word 0 (ID), then word 1 (timestamp),
//  one transaction at a time. It compares both words against the expected values and reports the result.
//  Sits beside the HPS bridge. The FPGA can self-check that the loaded image matches the software build before the TFT pipeline is enabled.
// PARAMETERS
//  EXPECTED_ID     32'hACD5_1302  expected value at word address 0
//  EXPECTED_TS     32'h565D_76CA  expected value at word address 1
//  TIMEOUT_CYCLES  1024           max cycles per phase (request+response), >=2
// PORTS
//  clock              in   1   single clock domain
//  reset              in   1   synchronous, active-high
//  start              in   1   one-cycle pulse; begins a check when idle
//  avm_address        out  1   word address (0=ID, 1=timestamp)
//  avm_read           out  1   read request
//  avm_waitrequest    in   1   slave stall; request accepted when read=1 and waitrequest=0
//  avm_readdata       in   32  read data
//  avm_readdatavalid  in   1   response strobe, latency >=1 after acceptance
//  busy               out  1   high from cycle after start until done
//  done               out  1   one-cycle pulse at end of check (pass, fail or timeout)
//  id_match           out  1   captured ID == EXPECTED_ID (sticky until next start)
//  ts_match           out  1   captured TS == EXPECTED_TS (sticky until next start)
//  timeout            out  1   a phase exceeded TIMEOUT_CYCLES (sticky until next start)
//  id_value           out  32  captured ID word
//  ts_value           out  32  captured timestamp word
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; timeout counter 0. Reset mid-transaction aborts it immediately.
//    Late readdatavalid after reset is ignored because the FSM is IDLE.
//  FSM states: IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, DONE.
//   IDLE   : start=1 -> REQ_ID. Clear id/ts_match, timeout, id_value and ts_value. busy=1.
//   REQ_ID : avm_read=1, avm_address=0, held stable while waitrequest=1; accept -> WAIT_ID.
//   WAIT_ID: avm_read=0; readdatavalid=1 -> capture id_value, set id_match -> REQ_TS.
//   REQ_TS : same handshake as REQ_ID with address=1; accept -> WAIT_TS.
//   WAIT_TS: readdatavalid=1 -> capture ts_value, set ts_match -> DONE.
//   DONE   : done=1 and busy=0 for this one cycle -> IDLE.
//  Timeout: counter clears on entry to each REQ state and counts in REQ/WAIT.
//    At count == TIMEOUT_CYCLES-1 without progress: timeout=1, avm_read dropped, -> DONE.
//    Progress means acceptance in REQ, or readdatavalid in WAIT.
//    Matches for words not yet captured stay 0.
//  Simultaneous: progress in the same cycle as count limit -> progress wins, no timeout.
//  start while busy or in DONE: ignored. readdatavalid outside a WAIT state: ignored.
//  Only one outstanding read; avm_read never asserted in WAIT/DONE/IDLE.
//  Latency (waitrequest=0, read latency 1): start at cycle 0 -> done pulse at cycle 5.
//  Comparisons are full 32-bit equality, registered together with capture.
// STRUCTURE
//  Package soc_system_sysid_pkg holds:
//   - FSM state enum
//   - SYSID_ADDR_ID=1'b0 and SYSID_ADDR_TS=1'b1
//   - SYSID_DATA_W=32
//  Sub-module soc_system_sysid_timeout_cnt: clear/enable counter with a limit-reached flag.
//    Its width is $clog2(TIMEOUT_CYCLES).
//  Everything else is in one FSM always block plus capture/compare registers.
// TESTING
//  1 Slave returns 0xACD51302/0x565D76CA, waitrequest=0, latency 1.
//    -> done at cycle 5; id_match=1, ts_match=1, timeout=0.
//  2 TS slot returns 0x00000000 -> id_match=1, ts_match=0, ts_value=0, timeout=0.
//  3 waitrequest held 3 cycles on each request, latency 4.
//    -> address/read stable while stalled; exactly 2 accepted reads; matches=1.
//  4 readdatavalid never returned for ID, TIMEOUT_CYCLES=16.
//    -> done 16 cycles after entering REQ_ID; timeout=1; id_match=0; avm_read=0.
//  5 start pulsed during WAIT_ID and during DONE -> ignored; only one check sequence runs.
//  6 reset asserted in WAIT_TS, stray readdatavalid after release.
//    -> all outputs 0, no capture; a new start completes normally.

Source files
------------

// File: rtl/soc_system_sysid_pkg.sv
// Shared types and constants for the system-ID self-check reader.
package soc_system_sysid_pkg;

  localparam int SYSID_DATA_W = 32;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_ID,
    ST_WAIT_ID,
    ST_REQ_TS,
    ST_WAIT_TS,
    ST_DONE
  } sysid_state_e;

endpackage

// File: rtl/soc_system_sysid_checker_if.sv
// Avalon-MM read-only bus between the checker (master) and the system-ID slave.
interface soc_system_sysid_checker_if;
  import soc_system_sysid_pkg::*;

  logic                    avm_address;
  logic                    avm_read;
  logic                    avm_waitrequest;
  logic [SYSID_DATA_W-1:0] avm_readdata;
  logic                    avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );

endinterface

// File: rtl/soc_system_sysid_timeout_cnt.sv
// Per-phase watchdog: clear/enable up-counter that parks on LIMIT-1 and flags it.
module soc_system_sysid_timeout_cnt #(
  parameter int LIMIT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int W = $clog2(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  assign hit = (cnt == LAST);

  // Count phase cycles; hold at the limit so the flag stays asserted until cleared.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && !hit) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/soc_system_sysid_checker.sv
// Reads system-ID word 0 (ID) then word 1 (timestamp) and compares both
// against the build-time expected values.
//
//  state    | meaning
//  ---------+-----------------------------------------------
//  IDLE     | waiting for start
//  REQ_ID   | read of word 0 presented, waiting for accept
//  WAIT_ID  | ID read accepted, waiting for readdatavalid
//  REQ_TS   | read of word 1 presented, waiting for accept
//  WAIT_TS  | TS read accepted, waiting for readdatavalid
//  DONE     | one-cycle done pulse, busy low
module soc_system_sysid_checker
  import soc_system_sysid_pkg::*;
#(
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID    = 32'hACD5_1302,
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_TS    = 32'h565D_76CA,
  parameter int                      TIMEOUT_CYCLES = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  soc_system_sysid_checker_if.master    avm,
  output logic                          busy,
  output logic                          done,
  output logic                          id_match,
  output logic                          ts_match,
  output logic                          timeout,
  output logic [SYSID_DATA_W-1:0]       id_value,
  output logic [SYSID_DATA_W-1:0]       ts_value
);

  sysid_state_e state;
  logic         read_q;
  logic         addr_q;
  logic         in_req;
  logic         in_wait;
  logic         accept;
  logic         progress;
  logic         cnt_clr;
  logic         cnt_hit;
  logic         phase_expired;

  assign avm.avm_read    = read_q;
  assign avm.avm_address = addr_q;

  assign in_req   = (state == ST_REQ_ID) || (state == ST_REQ_TS);
  assign in_wait  = (state == ST_WAIT_ID) || (state == ST_WAIT_TS);
  assign accept   = read_q && !avm.avm_waitrequest;
  assign progress = (in_req && accept) || (in_wait && avm.avm_readdatavalid);

  // The counter restarts exactly when a REQ state is entered, so each phase
  // gets its own TIMEOUT_CYCLES budget covering request plus response.
  assign cnt_clr = ((state == ST_IDLE) && start) ||
                   ((state == ST_WAIT_ID) && avm.avm_readdatavalid);

  // Progress on the last allowed cycle still counts as success.
  assign phase_expired = (in_req || in_wait) && cnt_hit && !progress;

  soc_system_sysid_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (in_req || in_wait),
    .hit   (cnt_hit)
  );

  // Sequencer with registered bus and status outputs, captures and compares.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      read_q   <= 1'b0;
      addr_q   <= SYSID_ADDR_ID;
      busy     <= 1'b0;
      done     <= 1'b0;
      id_match <= 1'b0;
      ts_match <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      done <= 1'b0;
      if (phase_expired) begin
        state   <= ST_DONE;
        read_q  <= 1'b0;
        timeout <= 1'b1;
        busy    <= 1'b0;
        done    <= 1'b1;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start) begin
              state    <= ST_REQ_ID;
              read_q   <= 1'b1;
              addr_q   <= SYSID_ADDR_ID;
              busy     <= 1'b1;
              id_match <= 1'b0;
              ts_match <= 1'b0;
              timeout  <= 1'b0;
              id_value <= '0;
              ts_value <= '0;
            end
          end
          ST_REQ_ID: begin
            if (accept) begin
              state  <= ST_WAIT_ID;
              read_q <= 1'b0;
            end
          end
          ST_WAIT_ID: begin
            if (avm.avm_readdatavalid) begin
              state    <= ST_REQ_TS;
              id_value <= avm.avm_readdata;
              id_match <= (avm.avm_readdata == EXPECTED_ID);
              read_q   <= 1'b1;
              addr_q   <= SYSID_ADDR_TS;
            end
          end
          ST_REQ_TS: begin
            if (accept) begin
              state  <= ST_WAIT_TS;
              read_q <= 1'b0;
            end
          end
          ST_WAIT_TS: begin
            if (avm.avm_readdatavalid) begin
              state    <= ST_DONE;
              ts_value <= avm.avm_readdata;
              ts_match <= (avm.avm_readdata == EXPECTED_TS);
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state  <= ST_IDLE;
            read_q <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// Directed bench for the system-ID checker with a behavioural Avalon slave
// and a scoreboard of expected check results.
module tb_soc_system_sysid_checker;

  localparam logic [31:0] ID_OK = 32'hACD5_1302;
  localparam logic [31:0] TS_OK = 32'h565D_76CA;
  localparam int          TO    = 16;

  typedef struct {
    logic        idm;
    logic        tsm;
    logic        to;
    logic [31:0] idv;
    logic [31:0] tsv;
    int          lat;
    int          nacc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, id_match, ts_match, timeout;
  logic [31:0] id_value, ts_value;

  soc_system_sysid_checker_if bus ();

  soc_system_sysid_checker #(
    .EXPECTED_ID    (ID_OK),
    .EXPECTED_TS    (TS_OK),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .avm      (bus),
    .busy     (busy),
    .done     (done),
    .id_match (id_match),
    .ts_match (ts_match),
    .timeout  (timeout),
    .id_value (id_value),
    .ts_value (ts_value)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  exp_t sb[$];

  always @(posedge clock) cyc <= cyc + 1;

  // slave configuration
  int          wait_cycles = 0;
  int          latency     = 1;
  logic [31:0] id_data     = ID_OK;
  logic [31:0] ts_data     = TS_OK;
  bit          drop_id     = 1'b0;
  logic        stray       = 1'b0;

  int          stall_cnt = 0;
  int          resp_cnt  = 0;
  int          acc_cnt   = 0;
  logic        rdv_r     = 1'b0;
  logic [31:0] rdata_r   = '0;
  logic        pend_addr = 1'b0;

  assign bus.avm_waitrequest   = bus.avm_read && (stall_cnt < wait_cycles);
  assign bus.avm_readdatavalid = rdv_r | stray;
  assign bus.avm_readdata      = rdata_r;

  // Behavioural slave: configurable stall count and fixed read latency.
  always @(posedge clock) begin
    rdv_r <= 1'b0;
    if (bus.avm_read && bus.avm_waitrequest) stall_cnt <= stall_cnt + 1;
    else stall_cnt <= 0;
    if (bus.avm_read && !bus.avm_waitrequest) begin
      acc_cnt <= acc_cnt + 1;
      if (!(drop_id && bus.avm_address == 1'b0)) begin
        if (latency <= 1) begin
          rdv_r   <= 1'b1;
          rdata_r <= bus.avm_address ? ts_data : id_data;
        end else begin
          resp_cnt  <= latency - 1;
          pend_addr <= bus.avm_address;
        end
      end
    end else if (resp_cnt > 0) begin
      resp_cnt <= resp_cnt - 1;
      if (resp_cnt == 1) begin
        rdv_r   <= 1'b1;
        rdata_r <= pend_addr ? ts_data : id_data;
      end
    end
  end

  logic prev_stall = 1'b0;
  logic prev_addr  = 1'b0;

  // A stalled request must keep read and address unchanged into the next cycle.
  always @(negedge clock) begin
    if (prev_stall && !reset) begin
      checks++;
      assert (bus.avm_read === 1'b1 && bus.avm_address === prev_addr)
      else begin
        errors++;
        $error("FAIL stall_hold observed read=%b addr=%b expected read=1 addr=%b",
               bus.avm_read, bus.avm_address, prev_addr);
      end
    end
    prev_stall = bus.avm_read && bus.avm_waitrequest && !reset;
    prev_addr  = bus.avm_address;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input exp_t e, output int t0, output int acc0);
    sb.push_back(e);
    acc0  = acc_cnt;
    t0    = cyc;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic finish_run(input string tag, input int t0, input int acc0);
    exp_t e;
    int   dc;
    dc = -1;
    for (int i = 0; i < 200; i++) begin
      if (done === 1'b1) begin
        dc = cyc;
        break;
      end
      @(negedge clock);
    end
    e = sb.pop_front();
    chk({tag, "_done_seen"}, 64'(dc >= 0), 64'(1));
    chk({tag, "_latency"},   64'(dc - t0), 64'(e.lat));
    chk({tag, "_id_match"},  64'(id_match), 64'(e.idm));
    chk({tag, "_ts_match"},  64'(ts_match), 64'(e.tsm));
    chk({tag, "_timeout"},   64'(timeout),  64'(e.to));
    chk({tag, "_id_value"},  64'(id_value), 64'(e.idv));
    chk({tag, "_ts_value"},  64'(ts_value), 64'(e.tsv));
    chk({tag, "_busy_rd"},   64'({busy, bus.avm_read}), 64'(0));
    chk({tag, "_accepts"},   64'(acc_cnt - acc0), 64'(e.nacc));
  endtask

  task automatic run_check(input string tag, input exp_t e);
    int t0, acc0;
    launch(e, t0, acc0);
    finish_run(tag, t0, acc0);
    repeat (3) @(negedge clock);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flags"},
        64'({busy, done, id_match, ts_match, timeout, bus.avm_read, bus.avm_address}), 64'(0));
    chk({tag, "_values"}, {id_value, ts_value}, 64'(0));
  endtask

  initial begin
    int t0, acc0, seen;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk_all_zero("reset");

    // 1: nominal, zero wait, latency 1 -> done at cycle 5
    run_check("nominal", '{1'b1, 1'b1, 1'b0, ID_OK, TS_OK, 5, 2});

    // 2: timestamp slot returns zero
    ts_data = 32'h0;
    run_check("ts_zero", '{1'b1, 1'b0, 1'b0, ID_OK, 32'h0, 5, 2});

    // 2b: ID off by one bit, TS good
    id_data = ID_OK ^ 32'h1;
    ts_data = TS_OK;
    run_check("id_bit0", '{1'b0, 1'b1, 1'b0, ID_OK ^ 32'h1, TS_OK, 5, 2});
    id_data = ID_OK;

    // 3: 3 stall cycles per request, latency 4
    wait_cycles = 3;
    latency     = 4;
    run_check("stall", '{1'b1, 1'b1, 1'b0, ID_OK, TS_OK, 17, 2});
    wait_cycles = 0;

    // 4: ID response never returned -> timeout 16 cycles after REQ_ID entry
    latency = 1;
    drop_id = 1'b1;
    run_check("no_rdv", '{1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 17, 1});
    drop_id = 1'b0;

    // response on the last allowed cycle of each phase wins over timeout
    latency = TO - 1;
    run_check("edge_ok", '{1'b1, 1'b1, 1'b0, ID_OK, TS_OK, 33, 2});

    // one cycle later is too late; the late strobe lands in DONE and is ignored
    latency = TO;
    run_check("edge_late", '{1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 17, 1});

    // 5: start during WAIT_ID and during DONE is ignored
    latency = 4;
    launch('{1'b1, 1'b1, 1'b0, ID_OK, TS_OK, 11, 2}, t0, acc0);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    finish_run("restart", t0, acc0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    chk("restart_idle", 64'({busy, bus.avm_read}), 64'(0));
    chk("restart_total_accepts", 64'(acc_cnt - acc0), 64'(2));

    // 6: reset while waiting for the TS word, then stray strobes
    acc0  = acc_cnt;
    t0    = cyc;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    chk("pre_reset_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    seen  = 0;
    for (int i = 0; i < 8; i++) begin
      stray = (i == 4);
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    stray = 1'b0;
    chk("post_reset_quiet", 64'(seen), 64'(0));
    chk_all_zero("post_reset");
    latency = 1;
    run_check("after_reset", '{1'b1, 1'b1, 1'b0, ID_OK, TS_OK, 5, 2});

    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
